// File: rtl/lanzones_pkg.sv
// Shared types and constants for the lanzones instruction memory.
package lanzones_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_LOAD,
    S_IDLE,
    S_READ,
    S_RESP
  } imem_state_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [XLEN-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/lanzones_imem_ram.sv
// Single-port instruction RAM: synchronous write, registered synchronous read, no reset.
module lanzones_imem_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 32,
  parameter int unsigned AW    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lanzones_imem.sv
// Instruction memory: loader port fills the RAM, then serves core fetches.
// Optional per-word even parity with sticky ParErr when LANZONES_IMEM_PARITY_EN is defined.
module lanzones_imem
  import lanzones_pkg::*;
#(
  parameter int unsigned     DEPTH    = 256,
  parameter int unsigned     AW       = $clog2(DEPTH),
  parameter logic [XLEN-1:0] OOR_WORD = NOP_WORD
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            LdVld,
  input  logic [XLEN-1:0] LdAddr,
  input  logic [XLEN-1:0] LdData,
  input  logic            LdLast,
  output logic            LdRdy,
  output logic            LEn,
  input  logic            RRdy,
  input  logic [XLEN-1:0] RAddr,
  output logic            RVld,
  output logic [XLEN-1:0] RData,
`ifdef LANZONES_IMEM_PARITY_EN
  output logic            ParErr,
`endif
  output logic            OorErr
);

`ifdef LANZONES_IMEM_PARITY_EN
  localparam int unsigned RamW = XLEN + 1;
`else
  localparam int unsigned RamW = XLEN;
`endif

  imem_state_t     state_q, state_d;
  logic            rvld_q, rvld_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            oor_err_q, oor_err_d;
  logic            oor_q, oor_d;

  logic            ld_oor, fetch_oor, fetch_req;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [RamW-1:0] ram_wdata, ram_rdata;

  // Full 32-bit compares so high address bits are never silently aliased.
  assign ld_oor    = LdAddr >= XLEN'(DEPTH);
  assign fetch_oor = RAddr >= XLEN'(DEPTH);
  assign fetch_req = (state_q == S_IDLE) && RRdy;
  assign ram_we    = (state_q == S_LOAD) && LdVld && !ld_oor;
  assign ram_addr  = (state_q == S_LOAD) ? LdAddr[AW-1:0] : RAddr[AW-1:0];

`ifdef LANZONES_IMEM_PARITY_EN
  logic par_err_q, par_err_d;
  assign ram_wdata = {even_parity(LdData), LdData};
`else
  assign ram_wdata = LdData;
`endif

  lanzones_imem_ram #(
    .Depth (DEPTH),
    .Width (RamW),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (fetch_req),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    rvld_d    = rvld_q;
    rdata_d   = rdata_q;
    oor_err_d = oor_err_q;
    oor_d     = oor_q;
`ifdef LANZONES_IMEM_PARITY_EN
    par_err_d = par_err_q;
`endif
    unique case (state_q)
      S_LOAD: begin
        if (LdVld) begin
          if (ld_oor) begin
            oor_err_d = 1'b1;
          end
          if (LdLast) begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (RRdy) begin
          oor_d   = fetch_oor;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rvld_d  = 1'b1;
        state_d = S_RESP;
        if (oor_q) begin
          rdata_d   = OOR_WORD;
          oor_err_d = 1'b1;
        end else begin
          rdata_d = ram_rdata[XLEN-1:0];
`ifdef LANZONES_IMEM_PARITY_EN
          if (even_parity(ram_rdata[XLEN-1:0]) != ram_rdata[XLEN]) begin
            par_err_d = 1'b1;
          end
`endif
        end
      end
      S_RESP: begin
        // Word stays on RData until the core takes it.
        if (RRdy) begin
          rvld_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_LOAD;
      rvld_q    <= 1'b0;
      rdata_q   <= '0;
      oor_err_q <= 1'b0;
      oor_q     <= 1'b0;
`ifdef LANZONES_IMEM_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rvld_q    <= rvld_d;
      rdata_q   <= rdata_d;
      oor_err_q <= oor_err_d;
      oor_q     <= oor_d;
`ifdef LANZONES_IMEM_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign LdRdy  = (state_q == S_LOAD);
  assign LEn    = (state_q != S_LOAD);
  assign RVld   = rvld_q;
  assign RData  = rdata_q;
  assign OorErr = oor_err_q;
`ifdef LANZONES_IMEM_PARITY_EN
  assign ParErr = par_err_q;
`endif

endmodule
